// File: rtl/split_vec_sampler_pkg.sv
// Shared types and helpers for the split constraint vector sampler.
package split_sampler_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  localparam int STAT_W = 16;

  function automatic int num_words(input int vec_w, input int word_w);
    return (vec_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/split_word_packer.sv
// Packs a stream of WORD_W words into a VEC_W vector; the final slot keeps
// only the low bits that fit inside VEC_W.
module split_word_packer
  import split_sampler_pkg::*;
#(
  parameter int VEC_W  = 512,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [WORD_W-1:0] word,
  output logic              last,
  output logic [VEC_W-1:0]  vec
);

  localparam int NW = num_words(VEC_W, WORD_W);
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;

  logic [KW-1:0] k;

  assign last = load_en && (k == KW'(NW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       k <= '0;
    else if (load_en) k <= last ? '0 : k + KW'(1);
  end

  for (genvar g = 0; g < NW; g++) begin : g_slot
    localparam int SW = (g == NW - 1) ? (VEC_W - g * WORD_W) : WORD_W;
    logic [SW-1:0] slot;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            slot <= '0;
      else if (load_en && (k == KW'(g)))     slot <= word[SW-1:0];
    end

    assign vec[g*WORD_W +: SW] = slot;
  end

endmodule

// File: rtl/split_vec_sampler.sv
// Rejection sampler: fills a candidate vector from random words, samples the
// split checker verdict and forwards accepted vectors. Optional counters
// under SPLIT_SAMPLER_STATS_EN.
module split_vec_sampler
  import split_sampler_pkg::*;
#(
  parameter int VEC_W     = 512,
  parameter int WORD_W    = 32,
  parameter int MAX_TRIES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic [VEC_W-1:0]  cand_vec,
  input  logic              check_ok,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_W-1:0]  out_vec,
  output logic              fail,
`ifdef SPLIT_SAMPLER_STATS_EN
  output logic [STAT_W-1:0] acc_cnt,
  output logic [STAT_W-1:0] rej_cnt,
`endif
  input  logic              clr
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e        state, state_nxt;
  logic          live;
  logic          last;
  logic [TW-1:0] try_cnt, try_nxt;
  logic          rej_last;

  assign try_nxt  = try_cnt + TW'(1);
  assign rej_last = (try_nxt == TW'(MAX_TRIES));

  split_word_packer #(.VEC_W(VEC_W), .WORD_W(WORD_W)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (in_valid && in_ready),
    .word    (in_data),
    .last    (last),
    .vec     (cand_vec)
  );

  // Holds in_ready low for the first cycle out of reset so every output is 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD:  if (last)      state_nxt = ST_CHECK;
      ST_CHECK: if (check_ok)  state_nxt = ST_OUT;
                else           state_nxt = rej_last ? ST_FAIL : ST_LOAD;
      ST_OUT:   if (out_ready) state_nxt = ST_LOAD;
      ST_FAIL:  if (clr)       state_nxt = ST_LOAD;
      default:                 state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    in_ready  = live && (state == ST_LOAD);
    out_valid = (state == ST_OUT);
  end

  // The verdict of a CHECK cycle takes precedence over a coincident clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      try_cnt <= '0;
      fail    <= 1'b0;
    end else if (state == ST_CHECK) begin
      if (check_ok) try_cnt <= '0;
      else begin
        try_cnt <= try_nxt;
        if (rej_last) fail <= 1'b1;
      end
    end else if (clr) begin
      try_cnt <= '0;
      fail    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             out_vec <= '0;
    else if (state == ST_CHECK && check_ok) out_vec <= cand_vec;
  end

`ifdef SPLIT_SAMPLER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
    end else if (state == ST_CHECK) begin
      if (check_ok && (acc_cnt != '1))  acc_cnt <= acc_cnt + STAT_W'(1);
      if (!check_ok && (rej_cnt != '1)) rej_cnt <= rej_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_split_vec_sampler.sv
// Directed bench for split_vec_sampler (VEC_W=40, WORD_W=32, MAX_TRIES=4)
// with a queue of expected accepted vectors.
module tb_split_vec_sampler;

  localparam int VEC_W     = 40;
  localparam int WORD_W    = 32;
  localparam int MAX_TRIES = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_data = '0;
  logic [VEC_W-1:0]  cand_vec;
  logic              ok = 1'b0;
  logic              check_ok;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [VEC_W-1:0]  out_vec;
  logic              fail;
  logic              clr = 1'b0;
`ifdef SPLIT_SAMPLER_STATS_EN
  logic [15:0]       acc_cnt, rej_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [VEC_W-1:0] sb[$];

  assign check_ok = ok;

  always #5 clk = ~clk;

  split_vec_sampler #(.VEC_W(VEC_W), .WORD_W(WORD_W), .MAX_TRIES(MAX_TRIES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .cand_vec  (cand_vec),
    .check_ok  (check_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .fail      (fail),
`ifdef SPLIT_SAMPLER_STATS_EN
    .acc_cnt   (acc_cnt),
    .rej_cnt   (rej_cnt),
`endif
    .clr       (clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Two words then the CHECK cycle; returns one cycle after CHECK.
  task automatic attempt(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                         input logic ok_v);
    logic [VEC_W-1:0] e;
    e  = {w1[VEC_W-WORD_W-1:0], w0};
    ok = ok_v;
    if (ok_v) sb.push_back(e);
    send_word(w0);
    send_word(w1);
    chk("check_cand_vec", cand_vec, e);
    chk("check_in_ready", in_ready, 0);
    chk("check_out_valid", out_valid, 0);
    tick();
  endtask

  task automatic recv();
    int n = 0;
    logic [VEC_W-1:0] e;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) chk("recv_timeout", out_valid, 1);
    else begin
      e = sb.pop_front();
      chk("out_vec", out_vec, e);
    end
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cand_vec", cand_vec, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_fail", fail, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic accept with zero-wait handshake
    attempt(32'h11111111, 32'h22222222, 1'b1);
    chk("accept_out_valid_t2", out_valid, 1);
    chk("accept_in_ready_t2", in_ready, 0);
    recv();

    // Truncated upper word, then output stall
    attempt(32'hAAAAAAAA, 32'hFFFFFFFF, 1'b1);
    chk("trunc_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("stall_out_vec", out_vec, 40'hFF_AAAAAAAA);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    recv();

    // Three rejects then accept
    for (int i = 0; i < 3; i++) begin
      attempt(32'h1000 + i, 32'h2000 + i, 1'b0);
      chk("rej_in_ready_t2", in_ready, 1);
      chk("rej_out_valid", out_valid, 0);
      chk("rej_fail", fail, 0);
    end
    attempt(32'hDEADBEEF, 32'h000000C3, 1'b1);
    chk("late_accept_out_valid", out_valid, 1);
    recv();
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("stats_acc", acc_cnt, 3);
    chk("stats_rej", rej_cnt, 3);
`endif

    // MAX_TRIES consecutive rejects; counter restarted after the accept
    for (int i = 0; i < MAX_TRIES - 1; i++) begin
      attempt(32'h5A5A0000 + i, 32'h0000005A, 1'b0);
      chk("pre_fail_fail", fail, 0);
      chk("pre_fail_in_ready", in_ready, 1);
    end
    attempt(32'h5A5AFFFF, 32'h000000A5, 1'b0);
    chk("fail_set", fail, 1);
    chk("fail_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fail_hold_in_ready", in_ready, 0);
      chk("fail_hold_out_valid", out_valid, 0);
      chk("fail_hold_fail", fail, 1);
    end
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fail", fail, 0);
    chk("clr_in_ready", in_ready, 1);
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("stats_rej_after_fail", rej_cnt, 7);
    chk("stats_acc_after_fail", acc_cnt, 3);
`endif

    // Try counter cleared by clr: a full new run of rejects is needed to fail
    for (int i = 0; i < MAX_TRIES - 1; i++) begin
      attempt(32'h77770000 + i, 32'h00000077, 1'b0);
      chk("post_clr_fail", fail, 0);
    end
    attempt(32'h01234567, 32'h00000089, 1'b1);
    recv();

    // Reset mid-LOAD discards partial vector asynchronously
    ok = 1'b1;
    send_word(32'h12345678);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_cand_vec", cand_vec, 0);
    chk("midrst_out_vec", out_vec, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_fail", fail, 0);
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("midrst_acc", acc_cnt, 0);
    chk("midrst_rej", rej_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;
    attempt(32'hCAFEF00D, 32'h0000003C, 1'b1);
    chk("fresh_out_valid", out_valid, 1);
    recv();
`ifdef SPLIT_SAMPLER_STATS_EN
    chk("fresh_acc", acc_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
